// File: rtl/pico_mem_responder.sv
// Memory responder for the picorv32 native interface: word RAM, GPIO register and
// free-running cycle counter behind a mem_valid/mem_ready handshake with optional wait states.
module pico_mem_responder #(
  parameter int          MEM_WORDS   = 256,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] IO_BASE     = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic [31:0] gpio_out,
  output logic        access_fault
);

  localparam int          AW        = $clog2(MEM_WORDS * 4);
  localparam logic [31:0] RAM_BYTES = 32'(MEM_WORDS * 4);
  localparam logic [31:0] CYC_ADDR  = IO_BASE + 32'd4;
  localparam logic [3:0]  WS_M1     = 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] gpio_q, gpio_d;
  logic [31:0] cycles_q, cycles_d;
  logic        fault_q, fault_d;
  logic        capture;

  logic [31:0] ram_q [MEM_WORDS];
  logic [3:0]  ram_we;

  logic [31:0]   word_addr;
  logic [AW-3:0] ram_idx;
  logic          hit_ram, hit_gpio, hit_cyc, fault;
  logic          unused_addr_bits;

  // Decode ignores the byte offset; anything at or above RAM size faults instead of aliasing.
  assign word_addr        = {mem_addr[31:2], 2'b00};
  assign ram_idx          = mem_addr[AW-1:2];
  assign hit_ram          = word_addr < RAM_BYTES;
  assign hit_gpio         = word_addr == IO_BASE;
  assign hit_cyc          = word_addr == CYC_ADDR;
  assign fault            = !(hit_ram || hit_gpio || hit_cyc) || (mem_instr && (hit_gpio || hit_cyc));
  assign unused_addr_bits = ^mem_addr[1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      rdata_q    <= '0;
      gpio_q     <= '0;
      cycles_q   <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      rdata_q    <= rdata_d;
      gpio_q     <= gpio_d;
      cycles_q   <= cycles_d;
      fault_q    <= fault_d;
    end
  end

  // capture marks the edge that enters RESP: sample request, commit write, load response.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    capture    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_valid) begin
          if (WAIT_STATES == 0) begin
            state_d = S_RESP;
            capture = 1'b1;
          end else begin
            state_d    = S_WAIT;
            wait_cnt_d = WS_M1;
          end
        end
      end
      S_WAIT: begin
        if (!mem_valid) begin
          state_d = S_IDLE;
        end else if (wait_cnt_q == 4'd0) begin
          state_d = S_RESP;
          capture = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_ready    = (state_q == S_RESP);
    mem_rdata    = rdata_q;
    gpio_out     = gpio_q;
    access_fault = fault_q;
  end

  always_comb begin
    rdata_d  = rdata_q;
    gpio_d   = gpio_q;
    cycles_d = cycles_q + 32'd1;
    fault_d  = capture && fault;
    ram_we   = '0;
    if (capture) begin
      if (fault) begin
        rdata_d = '0;
      end else if (hit_ram) begin
        rdata_d = ram_q[ram_idx];
        ram_we  = reset ? 4'b0000 : mem_wstrb;
      end else if (hit_gpio) begin
        rdata_d = gpio_q;
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[b]) gpio_d[8*b +: 8] = mem_wdata[8*b +: 8];
      end else begin
        rdata_d = cycles_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (ram_we[b]) ram_q[ram_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
  end

endmodule
